// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of four upstream FIFOs into four downstream FIFOs, routed by
// the word's top two bits, with threshold broadcast and a sticky overflow flag.
module fifo_rr_scheduler #(
  parameter int          DATA_W       = 6,
  parameter int          NUM_CH       = 4,
  parameter int          TH_W         = 5,
  parameter int unsigned TH_FULL_DEF  = 6,
  parameter int unsigned TH_EMPTY_DEF = 1
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     init,
  input  logic [TH_W-1:0]          cfg_al_full,
  input  logic [TH_W-1:0]          cfg_al_empty,
  input  logic [NUM_CH-1:0]        up_empty,
  input  logic [NUM_CH*DATA_W-1:0] up_data,
  output logic [NUM_CH-1:0]        up_pop,
  input  logic [NUM_CH-1:0]        dn_al_full,
  input  logic [NUM_CH-1:0]        dn_full,
  output logic [NUM_CH-1:0]        dn_push,
  output logic [DATA_W-1:0]        dn_data,
  output logic [TH_W-1:0]          al_full_th,
  output logic [TH_W-1:0]          al_empty_th,
  output logic [1:0]               state,
  output logic                     idle,
  output logic                     err
);

  localparam int LANE_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t              st, st_nxt;
  logic [LANE_W-1:0]   last;
  logic [LANE_W-1:0]   lane;
  logic                infl;
  logic                grant_vld;
  logic [LANE_W-1:0]   grant;
  logic                pop_en;
  logic [DATA_W-1:0]   word;
  logic [1:0]          dest;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant     = last;
    for (int k = 1; k <= NUM_CH; k++) begin
      logic [LANE_W-1:0] idx;
      idx = last + LANE_W'(k);
      if (!grant_vld && !up_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Any almost-full downstream FIFO stalls every lane; init drains without new pops.
  assign pop_en = (st == S_ACTIVE) && !init && (dn_al_full == '0) && grant_vld;
  assign up_pop = pop_en ? (NUM_CH'(1) << grant) : '0;

  // The popped word arrives one cycle later; push strobes come straight from the
  // registered lane/in-flight state so the write lands in that same cycle.
  assign word    = up_data[lane*DATA_W +: DATA_W];
  assign dest    = word[DATA_W-1 -: 2];
  assign dn_push = (infl && !dn_full[dest]) ? (NUM_CH'(1) << dest) : '0;
  assign dn_data = infl ? word : '0;

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_INIT:   if (!init) st_nxt = S_IDLE;
      S_IDLE: begin
        if (init)              st_nxt = S_INIT;
        else if (!(&up_empty)) st_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        // The current in-flight word pushes this cycle regardless of the exit taken.
        if (init)            st_nxt = S_INIT;
        else if (&up_empty)  st_nxt = S_IDLE;
      end
      default:  st_nxt = S_INIT;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (RESET) begin
      st          <= S_INIT;
      last        <= LANE_W'(NUM_CH - 1);
      lane        <= '0;
      infl        <= 1'b0;
      err         <= 1'b0;
      al_full_th  <= TH_W'(TH_FULL_DEF);
      al_empty_th <= TH_W'(TH_EMPTY_DEF);
    end else begin
      st   <= st_nxt;
      infl <= pop_en;
      if (pop_en) begin
        lane <= grant;
        last <= grant;
      end
      if (infl && dn_full[dest]) err <= 1'b1;
      if (st == S_INIT && init) begin
        al_full_th  <= cfg_al_full;
        al_empty_th <= cfg_al_empty;
      end
    end
  end

  assign state = st;
  assign idle  = (st == S_IDLE) && !infl;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: behavioural upstream FIFOs, a per-cycle
// reference model of grant/push/state rules, and literal checks per scenario.
module tb_fifo_rr_scheduler;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        init = 1'b0;
  logic [4:0]  cfg_al_full = '0;
  logic [4:0]  cfg_al_empty = '0;
  logic [3:0]  up_empty = 4'hF;
  logic [23:0] up_data = '0;
  logic [3:0]  dn_al_full = '0;
  logic [3:0]  dn_full = '0;
  logic [3:0]  up_pop, dn_push;
  logic [5:0]  dn_data;
  logic [4:0]  al_full_th, al_empty_th;
  logic [1:0]  state;
  logic        idle, err;

  always #5 clk = ~clk;

  fifo_rr_scheduler dut (
    .clk(clk), .RESET(RESET), .init(init),
    .cfg_al_full(cfg_al_full), .cfg_al_empty(cfg_al_empty),
    .up_empty(up_empty), .up_data(up_data), .up_pop(up_pop),
    .dn_al_full(dn_al_full), .dn_full(dn_full),
    .dn_push(dn_push), .dn_data(dn_data),
    .al_full_th(al_full_th), .al_empty_th(al_empty_th),
    .state(state), .idle(idle), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO bank: pop sampled mid-cycle, data valid the cycle after the pop.
  logic [5:0] fifo_q [4][$];
  logic [3:0] pop_q = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_q[i] && fifo_q[i].size() > 0) up_data[i*6 +: 6] <= fifo_q[i].pop_front();
      up_empty[i] <= (fifo_q[i].size() == 0);
    end
  end

  task automatic load(input int ln, input logic [5:0] w);
    fifo_q[ln].push_back(w);
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] v;
    logic [5:0] d;
  } ev_t;

  ev_t        pop_log[$];
  ev_t        push_log[$];
  logic [1:0] st_log [0:4095];
  int         cyc = 0;

  // Reference model state, expressed as the values visible during the current cycle.
  int         m_state = 0;
  int         m_last  = 3;
  bit         m_infl  = 0;
  logic [5:0] m_word  = '0;
  bit         m_err   = 0;
  int         m_fth   = 6;
  int         m_eth   = 1;

  always @(negedge clk) begin
    logic [3:0] e_pop, e_push;
    bit         g_vld;
    int         g, d;
    pop_q = up_pop;
    if (up_pop != '0)  pop_log.push_back('{cyc, up_pop, 6'h0});
    if (dn_push != '0) push_log.push_back('{cyc, dn_push, dn_data});
    st_log[cyc % 4096] = state;

    g_vld = 0;
    g     = 0;
    if (m_state == 2 && !init && dn_al_full == 4'h0) begin
      for (int k = 1; k <= 4; k++) begin
        if (!g_vld && !up_empty[(m_last + k) % 4]) begin
          g_vld = 1;
          g     = (m_last + k) % 4;
        end
      end
    end
    e_pop  = g_vld ? 4'(1 << g) : 4'h0;
    d      = int'(m_word[5:4]);
    e_push = (m_infl && !dn_full[d]) ? 4'(1 << d) : 4'h0;

    check("cmp_state", 32'(state), 32'(m_state));
    check("cmp_up_pop", 32'(up_pop), 32'(e_pop));
    check("cmp_dn_push", 32'(dn_push), 32'(e_push));
    if (e_push != 4'h0) check("cmp_dn_data", 32'(dn_data), 32'(m_word));
    check("cmp_err", 32'(err), 32'(m_err));
    check("cmp_idle", 32'(idle), 32'(m_state == 1 && !m_infl));
    check("cmp_full_th", 32'(al_full_th), 32'(m_fth));
    check("cmp_empty_th", 32'(al_empty_th), 32'(m_eth));

    if (RESET) begin
      m_state = 0; m_last = 3; m_infl = 0; m_err = 0; m_fth = 6; m_eth = 1;
    end else begin
      if (m_infl && dn_full[d]) m_err = 1;
      if (m_state == 0 && init) begin
        m_fth = int'(cfg_al_full);
        m_eth = int'(cfg_al_empty);
      end
      m_infl = g_vld;
      if (g_vld) begin
        m_word = fifo_q[g][0];
        m_last = g;
      end
      case (m_state)
        0: if (!init) m_state = 1;
        1: if (init) m_state = 0; else if (up_empty != 4'hF) m_state = 2;
        2: if (init) m_state = 0; else if (up_empty == 4'hF) m_state = 1;
        default: m_state = 0;
      endcase
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    push_log.delete();
  endtask

  task automatic wait_pops(input int n, input string name);
    for (int t = 0; t < 40 && pop_log.size() < n; t++) step();
    check(name, 32'(pop_log.size() >= n), 32'd1);
  endtask

  function automatic logic [5:0] rr_word(input int ln, input int k);
    return 6'((((ln + k) % 4) << 4) | (ln * 4 + k));
  endfunction

  initial begin
    int n;
    // Reset and first exit from INIT
    step(); step();
    RESET = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_full_th", 32'(al_full_th), 32'd6);
    check("rst_empty_th", 32'(al_empty_th), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_up_pop", 32'(up_pop), 32'd0);
    check("rst_dn_push", 32'(dn_push), 32'd0);
    check("rst_dn_data", 32'(dn_data), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    step();
    check("post_rst_state", 32'(state), 32'd1);
    check("post_rst_idle", 32'(idle), 32'd1);

    // Single lane, two words, routed to lanes 3 and 0
    clear_logs();
    load(2, 6'h35); load(2, 6'h0A);
    repeat (8) step();
    check("t2_npop", 32'(pop_log.size()), 32'd2);
    check("t2_npush", 32'(push_log.size()), 32'd2);
    if (pop_log.size() == 2 && push_log.size() == 2) begin
      n = pop_log[0].cyc;
      check("t2_pop0", 32'(pop_log[0].v), 32'h4);
      check("t2_pop1", 32'(pop_log[1].v), 32'h4);
      check("t2_pop1_cyc", 32'(pop_log[1].cyc), 32'(n + 1));
      check("t2_push0_cyc", 32'(push_log[0].cyc), 32'(n + 1));
      check("t2_push0", 32'(push_log[0].v), 32'h8);
      check("t2_data0", 32'(push_log[0].d), 32'h35);
      check("t2_push1_cyc", 32'(push_log[1].cyc), 32'(n + 2));
      check("t2_push1", 32'(push_log[1].v), 32'h1);
      check("t2_data1", 32'(push_log[1].d), 32'h0A);
      check("t2_active_n2", 32'(st_log[(n + 2) % 4096]), 32'd2);
      check("t2_idle_n3", 32'(st_log[(n + 3) % 4096]), 32'd1);
    end

    // Round-robin over four full lanes from a fresh pointer
    RESET = 1'b1; step(); RESET = 1'b0; step();
    clear_logs();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) load(i, rr_word(i, k));
    repeat (20) step();
    check("t3_npop", 32'(pop_log.size()), 32'd12);
    check("t3_npush", 32'(push_log.size()), 32'd12);
    if (pop_log.size() == 12 && push_log.size() == 12) begin
      for (int j = 0; j < 12; j++) begin
        logic [5:0] w;
        w = rr_word(j % 4, j / 4);
        check("t3_pop_lane", 32'(pop_log[j].v), 32'(1 << (j % 4)));
        check("t3_pop_cyc", 32'(pop_log[j].cyc), 32'(pop_log[0].cyc + j));
        check("t3_data", 32'(push_log[j].d), 32'(w));
        check("t3_push_dest", 32'(push_log[j].v), 32'(1 << w[5:4]));
      end
    end

    // Backpressure: any almost-full stalls all pops; in-flight word still lands
    clear_logs();
    load(0, 6'h01); load(0, 6'h02); load(1, 6'h13); load(1, 6'h24);
    wait_pops(2, "t4_start");
    dn_al_full = 4'b0010;
    step(); step(); step();
    dn_al_full = 4'b0000;
    repeat (8) step();
    check("t4_npop", 32'(pop_log.size()), 32'd4);
    if (pop_log.size() == 4 && push_log.size() >= 2) begin
      check("t4_pop0", 32'(pop_log[0].v), 32'h1);
      check("t4_pop1", 32'(pop_log[1].v), 32'h2);
      check("t4_gap", 32'(pop_log[2].cyc - pop_log[1].cyc), 32'd4);
      check("t4_resume_lane", 32'(pop_log[2].v), 32'h1);
      check("t4_pop3", 32'(pop_log[3].v), 32'h2);
      check("t4_inflight_push", 32'(push_log[1].cyc), 32'(pop_log[1].cyc + 1));
    end

    // Overflow: dropped word sets sticky err
    clear_logs();
    load(2, 6'h1F);
    wait_pops(1, "t5_start");
    dn_full = 4'b0010;
    step();
    dn_full = 4'b0000;
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_dropped", 32'(push_log.size()), 32'd0);
    load(0, 6'h05);
    repeat (6) step();
    check("t5_later_push", 32'(push_log.size()), 32'd1);
    if (push_log.size() == 1) check("t5_later_dest", 32'(push_log[0].v), 32'h1);
    check("t5_err_sticky", 32'(err), 32'd1);
    RESET = 1'b1; step(); RESET = 1'b0;
    check("t5_err_clear", 32'(err), 32'd0);
    check("t5_rst_state", 32'(state), 32'd0);

    // Reconfiguration mid-stream
    clear_logs();
    cfg_al_full = 5'd12; cfg_al_empty = 5'd3;
    load(1, 6'h11); load(1, 6'h12); load(3, 6'h33); load(3, 6'h34);
    wait_pops(1, "t6_start");
    init = 1'b1;
    step();
    check("t6_state_init", 32'(state), 32'd0);
    check("t6_no_pop", 32'(pop_log.size()), 32'd1);
    check("t6_inflight_done", 32'(push_log.size()), 32'd1);
    check("t6_th_hold", 32'(al_full_th), 32'd6);
    step();
    check("t6_full_th", 32'(al_full_th), 32'd12);
    check("t6_empty_th", 32'(al_empty_th), 32'd3);
    init = 1'b0;
    repeat (10) step();
    check("t6_npop", 32'(pop_log.size()), 32'd4);
    check("t6_npush", 32'(push_log.size()), 32'd4);
    if (pop_log.size() == 4) begin
      check("t6_first_lane", 32'(pop_log[0].v), 32'h2);
      check("t6_resume_lane", 32'(pop_log[1].v), 32'h8);
    end
    check("t6_th_kept", 32'(al_full_th), 32'd12);
    check("t6_idle", 32'(state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Drains four upstream 6-bit FIFOs into four downstream FIFOs: round-robin arbitration, one word per cycle maximum.
- Routes each word by its destination field (data[5:4]).
- Distributes almost-empty/almost-full thresholds to every FIFO instance.
- Sits between the input FIFO bank and the output FIFO bank of the switching datapath.

Parameters:
- DATA_W, 6, word width (routing field is bits [DATA_W-1:DATA_W-2])
- NUM_CH, 4, number of upstream lanes and downstream lanes (fixed at 4; dest field is 2 bits)
- TH_W, 5, threshold width
- TH_FULL_DEF, 6, al_full_th reset value
- TH_EMPTY_DEF, 1, al_empty_th reset value

Ports:
- clk  in  1  clock
- RESET  in  1  synchronous, active-high reset
- init  in  1  config request: hold in INIT, load thresholds
- cfg_al_full  in  5  almost-full threshold to load
- cfg_al_empty  in  5  almost-empty threshold to load
- up_empty  in  4  empty flag per upstream FIFO
- up_data  in  24  upstream data, lane i at [6i+5:6i]; valid 1 cycle after up_pop[i]
- up_pop  out  4  one-hot read strobe to upstream FIFOs
- dn_al_full  in  4  almost-full per downstream FIFO
- dn_full  in  4  full per downstream FIFO
- dn_push  out  4  one-hot write strobe to downstream FIFOs
- dn_data  out  6  write data to downstream FIFOs
- al_full_th  out  5  almost-full threshold broadcast
- al_empty_th  out  5  almost-empty threshold broadcast
- state  out  2  FSM state: INIT=0, IDLE=1, ACTIVE=2
- idle  out  1  1 when state==IDLE and nothing in flight
- err  out  1  sticky overflow error

Behaviour:
- Interface:
  - One clock (clk).
  - Reset (RESET) is synchronous and active-high.
  - All state updates on posedge clk.
- Reset values:
  - state=INIT; up_pop=0; dn_push=0; dn_data=0; err=0; idle=0.
  - al_full_th=TH_FULL_DEF; al_empty_th=TH_EMPTY_DEF.
  - Round-robin pointer last=3, so lane 0 has first priority.
  - In-flight flag cleared.
- INIT:
  - While init=1, thresholds register cfg_* every cycle; no pops.
  - init=0 → IDLE next cycle.
- IDLE:
  - idle=1.
  - init=1 → INIT.
  - Else any up_empty==0 → ACTIVE.
- ACTIVE, grant rules:
  - Each cycle, grant the first lane with up_empty[i]==0, searching from (last+1) mod 4 upward.
  - Pop allowed only if dn_al_full==4'b0000 (conservative: any almost-full stalls all pops) and init==0.
  - On grant: up_pop[i]=1 (combinational, same cycle); last<=i; record lane and set in-flight.
  - No grant → last unchanged.
- Latency:
  - Pop at cycle N → dn_push[dest]=1 and dn_data=up_data[lane] at cycle N+1 (registered outputs), with dest=word[5:4].
  - Back-to-back pops allowed: throughput 1 word/cycle.
- Overflow:
  - If dn_full[dest]==1 in the push cycle, the word is dropped, dn_push stays 0, and err<=1.
  - err stays 1 until RESET.
- ACTIVE exits:
  - All up_empty==1 and no in-flight → IDLE.
  - init=1 → stop popping, complete the in-flight push, then → INIT.
- Mid-operation RESET: in-flight word discarded; all outputs take reset values next cycle.
- dn_push and up_pop are never multi-hot.
- Thresholds change only in INIT.

Test Plan:
1. Reset check: RESET=1 for 2 cycles, then init=0 → state 0 then 1; al_full_th=6, al_empty_th=1; err=0; all strobes 0.
2. Single lane: lane 2 holds words 0x35 and 0x0A → up_pop=4'b0100 at N and N+1; dn_push=4'b1000 with dn_data=0x35 at N+1; dn_push=4'b0001 with 0x0A at N+2; returns to IDLE at N+3.
3. Round-robin: all four lanes non-empty, 3 words each → up_pop sequence 0001,0010,0100,1000 repeated; 12 consecutive pops, no gaps.
4. Backpressure: dn_al_full=4'b0010 raised mid-stream → up_pop=0 from that cycle; the one in-flight word still pushes; resumes with the next RR lane when dn_al_full clears.
5. Overflow: dn_full[1]=1 at the push cycle of word 0x1F → dn_push=0, err=1 sticky through later traffic until RESET.
6. Reconfig: init=1 during ACTIVE with cfg_al_full=12, cfg_al_empty=3 → in-flight push completes, state=0, thresholds read 12/3; init=0 → IDLE/ACTIVE, and RR resumes from last+1.
